// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: boot hold, load-use bubbles, data-memory
// wait stalls and stretched branch flushes for the PC unit and pipeline registers.
module pipe_hazard_ctrl #(
    parameter int REG_BITS     = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                boot_active,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_is_load,
    input  logic                ex_branch_taken,
    input  logic                mem_req,
    input  logic                mem_ready,
    output logic                stop,
    output logic                if_id_hold,
    output logic                id_ex_bubble,
    output logic                flush,
    output logic                mem_timeout_err,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        ST_BOOT     = 3'd0,
        ST_RUN      = 3'd1,
        ST_LU_STALL = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_FLUSH    = 3'd4
    } state_t;

    // The cycle that sees the branch is itself a flush cycle, so the FLUSH
    // state only needs to cover the remaining FLUSH_CYCLES-1 cycles.
    localparam bit         BR_EXTEND       = (FLUSH_CYCLES > 1);
    localparam logic [3:0] FLUSH_INIT_BOOT = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] FLUSH_INIT_BR   = BR_EXTEND ? 4'(FLUSH_CYCLES - 2) : 4'd0;
    localparam logic [7:0] WAIT_LIMIT      = 8'(MEM_TIMEOUT);

    state_t       state_r;
    logic [3:0]   flush_cnt_r;
    logic [7:0]   wait_cnt_r;
    logic         err_r;
    logic         lu_hazard_s;
    logic         mem_stall_s;
    logic         rs1_match_s;
    logic         rs2_match_s;

    // Hazard detection on the decode/execute pair and the memory stage
    always_comb begin
        rs1_match_s = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_match_s = id_use_rs2 && (id_rs2 == ex_rd);
        lu_hazard_s = ex_is_load && (ex_rd != {REG_BITS{1'b0}}) && (rs1_match_s || rs2_match_s);
        mem_stall_s = mem_req && !mem_ready;
    end

    // Sequencing FSM with its flush/wait counters and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_BOOT;
            flush_cnt_r <= 4'd0;
            wait_cnt_r  <= 8'd0;
            err_r       <= 1'b0;
        end else if (boot_active && (state_r != ST_BOOT)) begin
            state_r     <= ST_BOOT;
            flush_cnt_r <= 4'd0;
            wait_cnt_r  <= 8'd0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    if (!boot_active) begin
                        state_r     <= ST_FLUSH;
                        flush_cnt_r <= FLUSH_INIT_BOOT;
                    end
                end
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        if (BR_EXTEND) begin
                            state_r     <= ST_FLUSH;
                            flush_cnt_r <= FLUSH_INIT_BR;
                        end
                    end else if (mem_stall_s) begin
                        state_r    <= ST_MEM_WAIT;
                        wait_cnt_r <= 8'd1;
                    end else if (lu_hazard_s) begin
                        state_r <= ST_LU_STALL;
                    end
                end
                ST_LU_STALL: begin
                    state_r <= ST_RUN;
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        state_r    <= ST_RUN;
                        wait_cnt_r <= 8'd0;
                    end else if (wait_cnt_r == WAIT_LIMIT) begin
                        // Abandon the access: report it and let the pipe move on
                        state_r    <= ST_RUN;
                        wait_cnt_r <= 8'd0;
                        err_r      <= 1'b1;
                    end else if (wait_cnt_r != 8'hFF) begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_r == 4'd0) begin
                        state_r <= ST_RUN;
                    end else begin
                        flush_cnt_r <= flush_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r     <= ST_BOOT;
                    flush_cnt_r <= 4'd0;
                    wait_cnt_r  <= 8'd0;
                end
            endcase
        end
    end

    // Pipeline control decode; RUN follows the live inputs, other states are fixed
    always_comb begin
        stop         = 1'b1;
        if_id_hold   = 1'b0;
        id_ex_bubble = 1'b1;
        flush        = 1'b1;
        case (state_r)
            ST_BOOT: begin
                stop         = 1'b1;
                if_id_hold   = 1'b0;
                id_ex_bubble = 1'b1;
                flush        = 1'b1;
            end
            ST_RUN: begin
                if (ex_branch_taken) begin
                    stop         = 1'b0;
                    if_id_hold   = 1'b0;
                    id_ex_bubble = 1'b1;
                    flush        = 1'b1;
                end else if (mem_stall_s) begin
                    stop         = 1'b1;
                    if_id_hold   = 1'b1;
                    id_ex_bubble = 1'b0;
                    flush        = 1'b0;
                end else if (lu_hazard_s) begin
                    stop         = 1'b1;
                    if_id_hold   = 1'b1;
                    id_ex_bubble = 1'b1;
                    flush        = 1'b0;
                end else begin
                    stop         = 1'b0;
                    if_id_hold   = 1'b0;
                    id_ex_bubble = 1'b0;
                    flush        = 1'b0;
                end
            end
            ST_LU_STALL: begin
                stop         = 1'b0;
                if_id_hold   = 1'b0;
                id_ex_bubble = 1'b0;
                flush        = 1'b0;
            end
            ST_MEM_WAIT: begin
                stop         = 1'b1;
                if_id_hold   = 1'b1;
                id_ex_bubble = 1'b0;
                flush        = 1'b0;
            end
            ST_FLUSH: begin
                stop         = 1'b0;
                if_id_hold   = 1'b0;
                id_ex_bubble = 1'b1;
                flush        = 1'b1;
            end
            default: begin
                stop         = 1'b1;
                if_id_hold   = 1'b0;
                id_ex_bubble = 1'b1;
                flush        = 1'b1;
            end
        endcase
    end

    assign mem_timeout_err = err_r;
    assign state_dbg       = state_r;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the pipelined core. Drives the program-counter unit's stall (stop) input and the pipeline-register hold/bubble/flush controls.
- Holds the pipeline quiet while the boot/ROM-copy sequence runs.
- Inserts load-use bubbles, stalls on slow data-memory accesses, and stretches branch flushes.
- Sits between the decode/execute stage and the PC unit and pipeline registers.

Parameters:
REG_BITS, 5, width of register-index fields
FLUSH_CYCLES, 2, number of cycles the flush output stays high after a taken branch/jump (1..15)
MEM_TIMEOUT, 255, maximum cycles to wait for mem_ready before abandoning the access (1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
boot_active  input  1  high while the PC unit runs its ROM-copy/boot sequence
id_rs1  input  REG_BITS  source register 1 of instruction in decode
id_rs2  input  REG_BITS  source register 2 of instruction in decode
id_use_rs1  input  1  decode instruction reads rs1
id_use_rs2  input  1  decode instruction reads rs2
ex_rd  input  REG_BITS  destination register of instruction in execute
ex_is_load  input  1  execute instruction is a load
ex_branch_taken  input  1  execute resolved a taken branch/jal/jalr this cycle
mem_req  input  1  memory stage has a data access in progress
mem_ready  input  1  data memory completes access this cycle
stop  output  1  hold PC (drives PC unit stop)
if_id_hold  output  1  IF/ID register keeps its contents
id_ex_bubble  output  1  ID/EX register loads a NOP
flush  output  1  squash IF/ID and ID/EX contents
mem_timeout_err  output  1  sticky: a memory access exceeded MEM_TIMEOUT
state_dbg  output  3  current state encoding for display

Behaviour:
- Encodings: BOOT=0, RUN=1, LU_STALL=2, MEM_WAIT=3, FLUSH=4. state_dbg = state.
- Reset (async, any time, including mid-flush/mid-wait):
  - state=BOOT; flush counter=0; wait counter=0; mem_timeout_err=0.
  - Outputs during reset: stop=1, flush=1, if_id_hold=0, id_ex_bubble=1.
- Load-use hazard, lu = ex_is_load & (ex_rd != 0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- BOOT:
  - stop=1, flush=1, id_ex_bubble=1.
  - When boot_active is sampled low at a rising edge, go to FLUSH with counter=FLUSH_CYCLES-1. This guarantees a clean pipeline after boot.
- RUN: outputs are combinational on the current inputs. Priority, highest first:
  1. ex_branch_taken: flush=1, id_ex_bubble=1, stop=0. If FLUSH_CYCLES>1, next state=FLUSH with counter=FLUSH_CYCLES-2; otherwise stay in RUN.
  2. mem_req & !mem_ready: stop=1, if_id_hold=1, id_ex_bubble=0. Next state=MEM_WAIT, wait counter=1.
  3. lu: stop=1, if_id_hold=1, id_ex_bubble=1. Next state=LU_STALL.
  4. Otherwise all outputs 0.
- LU_STALL:
  - Lasts exactly one cycle. Outputs all 0; the hazard has cleared because the load has advanced.
  - Return to RUN. The total load-use penalty is 1 cycle.
- MEM_WAIT:
  - stop=1, if_id_hold=1, flush=0, id_ex_bubble=0. The execute stage is frozen, so ex_branch_taken is ignored here.
  - mem_ready=1: go to RUN, clear the counter.
  - Otherwise, if the wait counter == MEM_TIMEOUT: set mem_timeout_err and go to RUN. The access is treated as complete.
  - Otherwise increment the wait counter (8-bit, saturating).
- FLUSH:
  - flush=1, id_ex_bubble=1, stop=0.
  - Counter decrements each cycle; at 0, go to RUN.
  - A new ex_branch_taken in FLUSH is ignored; the squashed slot cannot hold a valid branch.
- boot_active rising while not in BOOT: go to BOOT on the next edge, which overrides all other transitions.
- mem_timeout_err is cleared only by reset.
- All next-state and counter updates happen on the rising clk edge. Outputs never glitch across reset release: the first edge after release still samples boot_active.

Test Plan:
1. Reset asserted mid-MEM_WAIT (wait counter=7) -> state_dbg=0, stop=1, flush=1 immediately (async). After release with boot_active=1 for 10 cycles, then 0 -> flush high 2 more cycles, then state_dbg=1, all outputs 0.
2. RUN, ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> that cycle stop=if_id_hold=id_ex_bubble=1; next cycle state_dbg=2, outputs 0; then RUN. Repeat with ex_rd=0 -> no stall.
3. RUN, mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 -> stop high 5 cycles total, back to RUN, mem_timeout_err=0.
4. MEM_TIMEOUT=3, mem_ready held 0 -> after 4 stall cycles state=RUN, mem_timeout_err=1 and it stays 1 until reset.
5. ex_branch_taken and lu asserted together in RUN -> flush=1, id_ex_bubble=1, stop=0, then FLUSH for 1 cycle (FLUSH_CYCLES=2), then RUN; no LU_STALL entered.
6. boot_active asserted while in RUN -> next edge state_dbg=0, stop=1. Deassert -> FLUSH_CYCLES flush cycles, then RUN.
